// File: rtl/segmented_state_reg.sv
// segmented_state_reg: segmented state register with per-segment/word load, rotate, clear and snapshot handshake.
// Optional segment write-lock enabled by defining SEG_STATE_LOCK_EN.
module segmented_state_reg #(
   parameter int WIDTH    = 8,
   parameter int SEGMENTS = 2,
   parameter int SEL_W    = 1,
   parameter int CNT_W    = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [1:0]          mode_i,
   input  logic [SEL_W-1:0]    select_i,
   input  logic [WIDTH-1:0]    data_in_i,
   input  logic                capture_i,
   input  logic                snap_ack_i,
`ifdef SEG_STATE_LOCK_EN
   input  logic [SEGMENTS-1:0] lock_mask_i,
   output logic                lock_viol_o,
`endif
   output logic [WIDTH-1:0]    state_o,
   output logic [WIDTH-1:0]    snap_o,
   output logic                snap_valid_o,
   output logic                overrun_o,
   output logic [SEGMENTS-1:0] dirty_o,
   output logic [CNT_W-1:0]    upd_count_o
);
   localparam int SEG_W = WIDTH / SEGMENTS;
   logic [WIDTH-1:0]    state_q, state_d, snap_q, snap_d;
   logic                snap_valid_q, snap_valid_d, overrun_q, overrun_d;
   logic [SEGMENTS-1:0] dirty_q, dirty_d, wr, sel_oh, lock;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept, op;
`ifdef SEG_STATE_LOCK_EN
   logic                lock_viol_q, lock_viol_d;
   assign lock        = lock_mask_i;
   assign lock_viol_d = load_i & |(lock & (mode_i == 2'b00 ? sel_oh : {SEGMENTS{1'b1}}));
   assign lock_viol_o = lock_viol_q;
`else
   assign lock = '0;
`endif
   always_comb begin
      sel_oh = '0;
      for (int k = 0; k < SEGMENTS; k++) sel_oh[k] = (int'(select_i) == k);
   end
   // wr holds the segments actually written this edge; it drives DIRTY and the counter
   always_comb begin
      state_d = state_q;
      wr      = '0;
      if (load_i && mode_i == 2'b10) begin
         if (lock == '0) begin
            state_d = {state_q[WIDTH-SEG_W-1:0], state_q[WIDTH-1 -: SEG_W]};
            wr      = '1;
         end
      end else if (load_i) begin
         for (int k = 0; k < SEGMENTS; k++)
            if ((mode_i != 2'b00 || sel_oh[k]) && !lock[k]) begin
               state_d[k*SEG_W +: SEG_W] = mode_i == 2'b11 ? {SEG_W{1'b0}} : data_in_i[k*SEG_W +: SEG_W];
               wr[k] = 1'b1;
            end
      end
   end
   assign op           = |wr;
   assign accept       = capture_i & (~snap_valid_q | snap_ack_i);
   assign snap_d       = accept ? state_q : snap_q;
   assign snap_valid_d = accept | (snap_valid_q & ~snap_ack_i);
   assign overrun_d    = capture_i & snap_valid_q & ~snap_ack_i;
   assign dirty_d      = accept ? wr : dirty_q | wr;
   assign cnt_d        = accept ? CNT_W'(op) : (op && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= '0;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         dirty_q      <= '0;
         cnt_q        <= '0;
`ifdef SEG_STATE_LOCK_EN
         lock_viol_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         overrun_q    <= overrun_d;
         dirty_q      <= dirty_d;
         cnt_q        <= cnt_d;
`ifdef SEG_STATE_LOCK_EN
         lock_viol_q  <= lock_viol_d;
`endif
      end
   end
   assign state_o      = state_q;
   assign snap_o       = snap_q;
   assign snap_valid_o = snap_valid_q;
   assign overrun_o    = overrun_q;
   assign dirty_o      = dirty_q;
   assign upd_count_o  = cnt_q;
endmodule
